dec_result_rob: RTL and testbench
=================================

DEC_RESULT_ROB -- requirements
Module: dec_result_rob

Interface
REQ-001 Parameter DEPTH, default 16, reorder window entries; power of two, 4..64.
REQ-002 Parameter ID_W, default 12, sample ID width; matches the classifier's out_ID.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 issue  input  1  pulse: one inference sample (mode 11) accepted by the classifier this cycle.
REQ-006 win_full  output  1  high when outstanding == DEPTH; feeder SHALL NOT pulse issue while high.
REQ-007 res_valid  input  1  classifier result strobe (its out_valid).
REQ-008 res_id  input  ID_W  result sample ID (its out_ID).
REQ-009 res_bit  input  1  result class (its out).
REQ-010 flush  input  1  level request to drain and restart the ID sequence at 0.
REQ-011 o_valid  output  1  in-order result available.
REQ-012 o_ready  input  1  consumer accepts; transfer when o_valid && o_ready.
REQ-013 o_id  output  ID_W  ID of the head result (first ID of a packed word when packing is compiled in).
REQ-014 o_data  output  PW  result payload; PW = 1, or 8 when packing is compiled in.
REQ-015 err  output  2  one-cycle error pulse: bit0 duplicate ID, bit1 ID outside window.

Function
REQ-016 IDs are issued sequentially from 0, modulo 2^ID_W; head_id = oldest unemitted ID; entry index = ID mod DEPTH.
REQ-017 outstanding = issued-not-emitted count, 0..DEPTH; incremented on issue, decremented on pop, unchanged when both occur in the same cycle.
REQ-018 A result is in-window iff (res_id - head_id) mod 2^ID_W < outstanding; in-window results set valid[idx] and data[idx].
REQ-019 An out-of-window result SHALL be dropped and pulse err[1] the next cycle.
REQ-020 A result whose entry is already valid SHALL be dropped and pulse err[0] the next cycle.
REQ-021 o_valid SHALL be driven from registered state only: valid[head] (unpacked), or pack-ready (packed); earliest o_valid is 1 cycle after the res_valid edge.
REQ-022 On pop: clear valid[head], advance head_id by 1 (wrapping from 2^ID_W-1 to 0); if res_valid targets the popped entry in the same cycle, the write wins.
REQ-023 o_valid && !o_ready SHALL hold o_valid, o_id and o_data stable.
REQ-024 FSM states RUN, DRAIN, CLEAR; reset enters RUN.
REQ-025 RUN -> DRAIN on flush; in DRAIN, issue is ignored and win_full is forced high; emission continues.
REQ-026 DRAIN -> CLEAR when outstanding == 0; CLEAR lasts 1 cycle, zeroes head_id and the valid bitmap, then returns to RUN.
REQ-027 Results arriving in CLEAR SHALL be dropped with err[1].

Reset
REQ-028 Reset SHALL clear the valid bitmap, head_id, outstanding and pack state, and enter RUN.
REQ-029 During and after reset: o_valid=0, o_id=0, o_data=0, err=0, win_full=0.
REQ-030 Reset mid-operation discards all held results, and the ID sequence restarts at 0.

Configuration
REQ-031 Macro DEC_ROB_PACK_EN.
REQ-032 Defined: 8 consecutive in-order results are packed LSB-first into o_data[7:0]; o_valid is raised when 8 are present.
REQ-033 Defined: in DRAIN, a trailing partial word is emitted zero-padded.
REQ-034 Defined: o_id is the ID of bit0, and one pop consumes all bits in the word.
REQ-035 Not defined: o_data is 1 bit and each pop consumes one result.

Structure
REQ-036 A shared package holds the FSM state enum, the err bit positions and default DEPTH/ID_W constants.
REQ-037 One sub-module, dec_rob_bitmap, holds the valid/data storage with a write port and a head read/clear port.

Verification
REQ-038 In-order: issue IDs 0..3, results 0..3 with bits 1,0,1,1, o_ready=1 -> o_id 0,1,2,3 with o_data 1,0,1,1.
REQ-039 Reorder: results in order 2,0,1 -> emission order 0,1,2, each ≥1 cycle after its res_valid.
REQ-040 Wrap: start at head_id 4094, issue 4 results -> o_id 4094,4095,0,1; out-of-window ID 100 -> err=2'b10, no output.
REQ-041 Backpressure/full: 16 issued, o_ready=0 -> win_full=1 with o_valid and o_data stable; one pop -> win_full=0.
REQ-042 Flush: flush with 3 outstanding -> DRAIN, 3 pops, CLEAR, RUN; next issued result has o_id 0; duplicate ID -> err=2'b01.
REQ-043 Packing (macro defined): 10 results, then flush -> o_data word of 8 bits with o_id 0, then a word with bits 9:8 zero-padded and o_id 8.

Source files
------------

// File: rtl/dec_result_rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_result_rob_pkg
// Purpose  : Shared types and constants for the classifier result reorder
//            buffer (FSM states, err bit positions, default geometry).
// Config   : DEC_ROB_PACK_EN selects an 8-bit packed output word.
// Revision : 1.0 - initial release
// ============================================================================
package dec_result_rob_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_ID_W  = 12;

`ifdef DEC_ROB_PACK_EN
  // Eight in-order results leave together, LSB = oldest
  localparam int PACK_W = 8;
`else
  localparam int PACK_W = 1;
`endif

  // Bit positions inside the err pulse
  localparam int ERR_DUP = 0;
  localparam int ERR_OOW = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } rob_state_e;

endpackage
`default_nettype wire

// File: rtl/dec_rob_bitmap.sv
`default_nettype none
// ============================================================================
// Module   : dec_rob_bitmap
// Purpose  : Valid/data storage of the reorder window. One write port with
//            an occupancy lookup, and a RD_W-wide read/clear window that
//            starts at the head entry and wraps modulo DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module dec_rob_bitmap #(
  parameter  int DEPTH = 16,
  parameter  int RD_W  = 1,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic            wr_bit,
  output logic            wr_hit,
  input  logic [IW-1:0]   hd_idx,
  output logic [RD_W-1:0] hd_valid,
  output logic [RD_W-1:0] hd_data,
  input  logic [RD_W-1:0] clr_mask,
  input  logic            clr_all
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] data_q,  data_d;

  // Occupancy of the write target, used for duplicate detection
  assign wr_hit = valid_q[wr_idx];

  // Head window read, wrapping around the end of the storage
  always_comb begin
    hd_valid = '0;
    hd_data  = '0;
    for (int i = 0; i < RD_W; i++) begin
      hd_valid[i] = valid_q[hd_idx + IW'(i)];
      hd_data[i]  = data_q[hd_idx + IW'(i)];
    end
  end

  // Next storage state: bulk clear, then head clear, then write (write wins)
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_all) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < RD_W; i++) begin
        if (clr_mask[i]) valid_d[hd_idx + IW'(i)] = 1'b0;
      end
    end
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      data_d[wr_idx]  = wr_bit;
    end
  end

  // Storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_result_rob.sv
`default_nettype none
// ============================================================================
// Module   : dec_result_rob
// Purpose  : Reorder buffer for classifier results. Samples get sequential
//            IDs on issue; results may come back in any order and are
//            emitted strictly in ID order. A flush drains the window and
//            restarts the ID sequence at 0.
// Config   : DEC_ROB_PACK_EN - emit 8 consecutive results per word (partial
//            trailing word during drain); undefined - one result per pop.
// Revision : 1.0 - initial release
// ============================================================================
module dec_result_rob
  import dec_result_rob_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  output logic              win_full,
  input  logic              res_valid,
  input  logic [ID_W-1:0]   res_id,
  input  logic              res_bit,
  input  logic              flush,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [ID_W-1:0]   o_id,
  output logic [PACK_W-1:0] o_data,
  output logic [1:0]        err
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  rob_state_e        state_q, state_d;
  logic [ID_W-1:0]   head_q,  head_d;
  logic [OW-1:0]     out_q,   out_d;
  logic [1:0]        err_q,   err_d;

  logic [ID_W-1:0]   res_off;
  logic              in_win;
  logic              issue_ok;
  logic              pop;
  logic              wr_en;
  logic              wr_hit;
  logic              clr_all;
  logic              still;
  logic [PACK_W-1:0] hd_valid;
  logic [PACK_W-1:0] hd_data;
  logic [PACK_W-1:0] run_mask;
  logic [OW-1:0]     run_len;

  dec_rob_bitmap #(
    .DEPTH (DEPTH),
    .RD_W  (PACK_W)
  ) u_bitmap (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (res_id[IW-1:0]),
    .wr_bit   (res_bit),
    .wr_hit   (wr_hit),
    .hd_idx   (head_q[IW-1:0]),
    .hd_valid (hd_valid),
    .hd_data  (hd_data),
    .clr_mask (pop ? run_mask : '0),
    .clr_all  (clr_all)
  );

  // Window is closed while draining so the feeder stops issuing
  assign win_full = (state_q == ST_DRAIN) || (out_q == OW'(DEPTH));
  assign issue_ok = issue && !win_full;

  // Distance from the head, modulo the ID space, decides window membership
  assign res_off = res_id - head_q;
  assign in_win  = {{OW{1'b0}}, res_off} < {{ID_W{1'b0}}, out_q};

  // Count of contiguous resolved results starting at the head
  always_comb begin
    run_len  = '0;
    run_mask = '0;
    still    = 1'b1;
    for (int i = 0; i < PACK_W; i++) begin
      if (still && hd_valid[i] && (OW'(i) < out_q)) begin
        run_len     = run_len + OW'(1);
        run_mask[i] = 1'b1;
      end else begin
        still = 1'b0;
      end
    end
  end

`ifdef DEC_ROB_PACK_EN
  // Full word ready, or the last partial word once draining has resolved it
  assign o_valid = (int'(run_len) == PACK_W) ||
                   ((state_q == ST_DRAIN) && (out_q != '0) && (run_len == out_q));
`else
  assign o_valid = (run_len != '0);
`endif

  assign pop    = o_valid && o_ready;
  assign o_id   = head_q;
  assign o_data = o_valid ? (hd_data & run_mask) : '0;
  assign err    = err_q;

  // Result classification, window bookkeeping and flush sequencing
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    out_d   = out_q;
    err_d   = '0;
    wr_en   = 1'b0;
    clr_all = 1'b0;

    if (res_valid) begin
      if ((state_q == ST_CLEAR) || !in_win) begin
        err_d[ERR_OOW] = 1'b1;
      end else if (wr_hit) begin
        err_d[ERR_DUP] = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end

    if (pop) head_d = head_q + ID_W'(run_len);
    out_d = out_q + (issue_ok ? OW'(1) : '0) - (pop ? run_len : '0);

    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_q == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        head_d  = '0;
        clr_all = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_result_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_result_rob
// Purpose  : Directed self-checking bench for dec_result_rob (DEPTH 16,
//            ID_W 12). With DEC_ROB_PACK_EN defined the packed-word sequence
//            runs instead of the single-bit sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_result_rob;
  import dec_result_rob_pkg::*;

  localparam int ID_W = 12;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              issue     = 1'b0;
  logic              res_valid = 1'b0;
  logic [ID_W-1:0]   res_id    = '0;
  logic              res_bit   = 1'b0;
  logic              flush     = 1'b0;
  logic              o_ready   = 1'b0;
  logic              win_full;
  logic              o_valid;
  logic [ID_W-1:0]   o_id;
  logic [PACK_W-1:0] o_data;
  logic [1:0]        err;

  int vectors     = 0;
  int miscompares = 0;

  dec_result_rob #(
    .DEPTH (16),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .win_full  (win_full),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_bit   (res_bit),
    .flush     (flush),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_id      (o_id),
    .o_data    (o_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Hard stop if the directed sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input int n);
    issue = 1'b1;
    repeat (n) tick();
    issue = 1'b0;
  endtask

  task automatic send(input int id, input logic b);
    res_valid = 1'b1;
    res_id    = ID_W'(id);
    res_bit   = b;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int id, input logic [31:0] d);
    check({tag, ".valid"}, 32'(o_valid), 32'd1);
    check({tag, ".id"},    32'(o_id),    32'(id));
    check({tag, ".data"},  32'(o_data),  d);
  endtask

  initial begin
    logic [3:0] bits4;
    logic [7:0] pat;
    bits4 = 4'b1101;
    pat   = 8'hA5;

    // Reset state
    tick();
    tick();
    check("rst.o_valid",  32'(o_valid),  32'd0);
    check("rst.o_id",     32'(o_id),     32'd0);
    check("rst.o_data",   32'(o_data),   32'd0);
    check("rst.err",      32'(err),      32'd0);
    check("rst.win_full", 32'(win_full), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef DEC_ROB_PACK_EN
    // Ten results, packed word of eight, then a zero-padded tail on flush
    o_ready = 1'b0;
    issue_n(10);
    for (int id = 0; id < 7; id++) send(id, pat[id]);
    check("pk.early", 32'(o_valid), 32'd0);
    send(7, pat[7]);
    expect_out("pk.w0", 0, 32'hA5);
    send(8, 1'b1);
    send(9, 1'b1);
    expect_out("pk.w0hold", 0, 32'hA5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("pk.w0drain", 0, 32'hA5);
    o_ready = 1'b1;
    tick();
    expect_out("pk.w1", 8, 32'h03);
    tick();
    check("pk.empty", 32'(o_valid), 32'd0);
    tick();
    tick();
    check("pk.restart", 32'(o_id), 32'd0);
`else
    o_ready = 1'b1;

    // In order: IDs 0..3, bits 1,0,1,1
    issue_n(4);
    for (int id = 0; id < 4; id++) begin
      send(id, bits4[id]);
      expect_out("ino", id, 32'(bits4[id]));
    end
    tick();
    check("ino.empty", 32'(o_valid), 32'd0);

    // Reorder: IDs 4,5,6 resolved as 6,4,5
    issue_n(3);
    send(6, 1'b1);
    check("ro.wait", 32'(o_valid), 32'd0);
    send(4, 1'b0);
    expect_out("ro.4", 4, 32'd0);
    send(5, 1'b1);
    expect_out("ro.5", 5, 32'd1);
    tick();
    expect_out("ro.6", 6, 32'd1);
    tick();
    check("ro.empty", 32'(o_valid), 32'd0);

    // Result with nothing outstanding is out of window
    send(100, 1'b0);
    check("oow.err",   32'(err),     32'd2);
    check("oow.valid", 32'(o_valid), 32'd0);
    tick();
    check("oow.clr",   32'(err),     32'd0);

    // Backpressure with the window full: IDs 7..22
    o_ready = 1'b0;
    issue_n(16);
    check("full.wf", 32'(win_full), 32'd1);
    send(7, 1'b1);
    expect_out("full.7", 7, 32'd1);
    send(8, 1'b0);
    expect_out("full.hold1", 7, 32'd1);
    tick();
    expect_out("full.hold2", 7, 32'd1);
    check("full.wf2", 32'(win_full), 32'd1);
    o_ready = 1'b1;
    tick();
    check("full.wf_pop", 32'(win_full), 32'd0);
    expect_out("full.8", 8, 32'd0);
    tick();
    for (int id = 9; id < 23; id++) begin
      send(id, id[0]);
      check("full.stream", 32'(o_id), 32'(id));
    end
    tick();
    check("full.empty", 32'(o_valid), 32'd0);

    // Flush with three outstanding (IDs 23..25)
    issue_n(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.drain_wf", 32'(win_full), 32'd1);
    issue_n(1);
    o_ready = 1'b0;
    send(23, 1'b1);
    expect_out("fl.23", 23, 32'd1);
    send(23, 1'b0);
    check("fl.dup_err", 32'(err), 32'd1);
    expect_out("fl.23hold", 23, 32'd1);
    o_ready = 1'b1;
    send(24, 1'b0);
    expect_out("fl.24", 24, 32'd0);
    send(25, 1'b1);
    expect_out("fl.25", 25, 32'd1);
    tick();
    check("fl.empty",    32'(o_valid),  32'd0);
    check("fl.drain_wf2", 32'(win_full), 32'd1);
    tick();
    check("fl.clear_wf", 32'(win_full), 32'd0);
    send(0, 1'b1);
    check("fl.clear_err", 32'(err),     32'd2);
    check("fl.clear_ov",  32'(o_valid), 32'd0);
    issue_n(1);
    send(0, 1'b1);
    expect_out("fl.restart", 0, 32'd1);
    tick();

    // Reset mid-operation drops held results and restarts the IDs
    issue_n(2);
    o_ready = 1'b0;
    send(1, 1'b1);
    expect_out("mr.held", 1, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr.o_valid", 32'(o_valid), 32'd0);
    check("mr.o_id",    32'(o_id),    32'd0);
    tick();
    rst_n   = 1'b1;
    o_ready = 1'b1;
    tick();
    issue_n(1);
    send(0, 1'b1);
    expect_out("mr.restart", 0, 32'd1);
    tick();

    // Walk the head up to 4094
    for (int id = 1; id < 4094; id++) begin
      issue_n(1);
      send(id, 1'b0);
      tick();
    end
    check("wrap.head", 32'(o_id), 32'd4094);

    // IDs 4094,4095,0,1 across the wrap; 100 lies outside the window
    issue_n(4);
    send(100, 1'b1);
    check("wrap.oow_err", 32'(err),     32'd2);
    check("wrap.oow_ov",  32'(o_valid), 32'd0);
    send(4094, 1'b1);
    expect_out("wrap.4094", 4094, 32'd1);
    send(4095, 1'b0);
    expect_out("wrap.4095", 4095, 32'd0);
    send(0, 1'b0);
    expect_out("wrap.0", 0, 32'd0);
    send(1, 1'b1);
    expect_out("wrap.1", 1, 32'd1);
    tick();
    check("wrap.empty", 32'(o_valid), 32'd0);
    check("wrap.next",  32'(o_id),    32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
